// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM access controller.
// Holds the grant encoding, default widths of the 2 x 96-bit masked macro,
// the response FIFO sizing and a pointer-wrap helper.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_W = 1;
  localparam int DEF_DATA_W = 96;
  localparam int DEF_MASK_W = 2;

  // The response FIFO depth is also the read credit limit.
  localparam int RESP_DEPTH = 2;
  localparam int RESP_CNT_W = $clog2(RESP_DEPTH + 1);
  localparam int RESP_PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  // Outstanding reads = FIFO count + one in-flight read, so it needs one more bit.
  localparam int RESP_OUT_W = RESP_CNT_W + 1;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_WRITE = 2'd1,
    GNT_READ  = 2'd2
  } grant_e;

  function automatic logic [RESP_PTR_W-1:0] resp_ptr_inc(input logic [RESP_PTR_W-1:0] ptr);
    return (ptr == RESP_PTR_W'(RESP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Read-response FIFO, RESP_DEPTH entries, valid/ready output side.
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_push, i_push_data write side (no ready: the caller's credit prevents overflow)
//   o_valid, o_data     head of queue
//   i_ready             consumer accepts the head when o_valid is high
//   o_count             occupancy, used by the caller as read credit
module sram_resp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_W-1:0]     i_push_data,
  output logic                  o_valid,
  output logic [DATA_W-1:0]     o_data,
  input  logic                  i_ready,
  output logic [RESP_CNT_W-1:0] o_count
);

  logic [DATA_W-1:0]     r_mem [RESP_DEPTH];
  logic [RESP_PTR_W-1:0] r_rd_ptr;
  logic [RESP_PTR_W-1:0] r_wr_ptr;
  logic [RESP_CNT_W-1:0] r_count;
  logic                  w_pop;

  assign w_pop   = o_valid && i_ready;
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // NOTE: storage is cleared too so the head shows zero data after reset,
      // not stale words from before it.
      for (int i = 0; i < RESP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= resp_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= resp_ptr_inc(r_rd_ptr);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The read credit upstream must never let a push land on a full queue.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_push) begin
      assert (r_count != RESP_CNT_W'(RESP_DEPTH));
    end
  end

endmodule

// File: rtl/sram_1p_access_ctrl.sv
// Access controller driving the RW0 port of a single-port masked SRAM.
// Arbitrates a write stream and a read stream onto the port (one access per
// cycle, alternating priority on conflicts) and buffers the one-cycle-latency
// read data in a small response FIFO so that responses survive consumer stalls.
// Ports:
//   clock, reset_n                       clock, synchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_mask/wr_data   write request stream
//   rd_valid/rd_ready/rd_addr            read request stream
//   resp_valid/resp_ready/resp_data      read response stream
//   mem_en/mem_wmode/mem_addr/mem_wmask/mem_wdata/mem_rdata   SRAM RW0 port
module sram_1p_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MASK_W = DEF_MASK_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_e                r_prio;
  logic                  r_rd_inflight;
  grant_e                w_grant;
  logic                  w_prio_flip;
  logic [RESP_CNT_W-1:0] w_fifo_count;
  logic [RESP_OUT_W-1:0] w_outstanding;
  logic                  w_resp_pop;
  logic                  w_rd_can;

  // A read may issue when a FIFO slot is guaranteed by the time its data
  // returns: either fewer than RESP_DEPTH reads are outstanding, or the head
  // is leaving this very cycle.
  assign w_outstanding = RESP_OUT_W'(w_fifo_count) + RESP_OUT_W'(r_rd_inflight);
  assign w_resp_pop    = resp_valid && resp_ready;
  assign w_rd_can      = (w_outstanding < RESP_OUT_W'(RESP_DEPTH)) || w_resp_pop;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave a latch behind.
  always_comb begin
    w_grant     = GNT_NONE;
    w_prio_flip = 1'b0;
    if (reset_n) begin
      if (wr_valid && rd_valid && w_rd_can) begin
        w_grant     = r_prio;
        w_prio_flip = 1'b1;
      end else if (wr_valid) begin
        // Also covers the credit-starved conflict: write wins, prio untouched.
        w_grant = GNT_WRITE;
      end else if (rd_valid && w_rd_can) begin
        w_grant = GNT_READ;
      end
    end
  end

  assign wr_ready = (w_grant == GNT_WRITE);
  assign rd_ready = (w_grant == GNT_READ);

  always_comb begin
    mem_en    = (w_grant != GNT_NONE);
    mem_wmode = (w_grant == GNT_WRITE);
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    case (w_grant)
      GNT_WRITE: begin
        mem_addr  = wr_addr;
        mem_wmask = wr_mask;
        mem_wdata = wr_data;
      end
      GNT_READ: mem_addr = rd_addr;
      default:  mem_addr = '0;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_inflight <= 1'b0;
      r_prio        <= GNT_WRITE;
    end else begin
      r_rd_inflight <= (w_grant == GNT_READ);
      if (w_prio_flip) begin
        r_prio <= (r_prio == GNT_WRITE) ? GNT_READ : GNT_WRITE;
      end
    end
  end

  // mem_rdata is valid the cycle after a read issue, exactly when r_rd_inflight
  // is set; a read in flight across a reset edge is dropped by the FIFO reset.
  sram_resp_fifo #(
    .DATA_W(DATA_W)
  ) u_resp_fifo (
    .i_clk      (clock),
    .i_rst_n    (reset_n),
    .i_push     (r_rd_inflight),
    .i_push_data(mem_rdata),
    .o_valid    (resp_valid),
    .o_data     (resp_data),
    .i_ready    (resp_ready),
    .o_count    (w_fifo_count)
  );

endmodule

// File: doc/sram_1p_access_ctrl.md
Name: sram_1p_access_ctrl

Overview:
- Request-side controller that sits directly upstream of the 2-entry x 96-bit single-port masked SRAM macro and drives its RW0 port.
- Accepts independent write and read request streams (valid/ready).
- Arbitrates them onto the single port, one access per cycle.
- Buffers one-cycle-latency read data into a 2-entry response FIFO with backpressure, so read data is never lost when the consumer stalls.

Parameters:
- ADDR_W, 1, SRAM address width (depth = 2^ADDR_W)
- DATA_W, 96, SRAM word width
- MASK_W, 2, write-mask lanes; lane width = DATA_W/MASK_W (48)

Ports:
- clock  in  1  single clock for block and SRAM
- reset_n  in  1  synchronous active-low reset
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted this cycle when high with wr_valid
- wr_addr  in  ADDR_W  write address
- wr_mask  in  MASK_W  per-lane write enable
- wr_data  in  DATA_W  write data
- rd_valid  in  1  read request valid
- rd_ready  out  1  read request accepted
- rd_addr  in  ADDR_W  read address
- resp_valid  out  1  read response valid
- resp_ready  in  1  consumer accepts response
- resp_data  out  DATA_W  read response data
- mem_en  out  1  to SRAM RW0_en
- mem_wmode  out  1  to SRAM RW0_wmode (1 = write)
- mem_addr  out  ADDR_W  to SRAM RW0_addr
- mem_wmask  out  MASK_W  to SRAM RW0_wmask
- mem_wdata  out  DATA_W  to SRAM RW0_wdata
- mem_rdata  in  DATA_W  from SRAM RW0_rdata, valid the cycle after a read issue

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (reset_n sampled on the rising edge of clock).
- Reset values: rd_inflight=0, FIFO count=0, resp_valid=0, resp_data=0, prio=WRITE.
  - mem_en=0 while reset_n=0.
  - wr_ready=rd_ready=0 while reset_n=0.
- Read credit: outstanding = rd_inflight + fifo_count. rd_can = (outstanding < 2) || (resp_valid && resp_ready).
- Arbitration (combinational, per cycle):
  - Write only valid: grant write.
  - Read only valid and rd_can: grant read.
  - Both valid and rd_can: grant the side indicated by prio, and prio toggles to the other side. prio changes only on such conflicts.
  - Both valid and !rd_can: grant write; prio unchanged.
- wr_ready = reset_n && (grant==WRITE); rd_ready = reset_n && (grant==READ). A ready is never asserted without its valid.
- SRAM drive:
  - mem_en = any grant.
  - mem_wmode = (grant==WRITE).
  - mem_addr, mem_wmask, mem_wdata are muxed from the granted side.
  - mem_wmask and mem_wdata are driven 0 on a read grant.
- Write latency: SRAM content is updated at the grant edge. A read granted in any later cycle returns the new data.
- Read pipeline:
  - A grant at cycle t sets rd_inflight at the end of t.
  - In cycle t+1, mem_rdata is pushed into the FIFO at the t+1 edge.
  - resp_valid is high from t+2, so the minimum request-to-response latency is 2 cycles.
  - Back-to-back reads sustain 1/cycle while resp_ready=1.
- Response FIFO:
  - 2 entries; resp_data/resp_valid show the head.
  - Pop on resp_valid && resp_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - The credit rule guarantees no overflow; a push into a full FIFO is a design error (assert).
- wr_mask=0: still consumes a grant and cycle; array unchanged.
- Reset mid-operation: an in-flight read is discarded, the FIFO is flushed, and prio returns to WRITE. There is no response for a dropped read.
- Address out of range is impossible at ADDR_W=1. For larger ADDR_W, depth is 2^ADDR_W and all addresses are legal.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - the grant enum (NONE, WRITE, READ)
  - default widths ADDR_W/DATA_W/MASK_W
  - FIFO depth constant RESP_DEPTH=2
- One sub-module: sram_resp_fifo, a 2-entry valid/ready FIFO with count output used for the credit.
- Arbiter and SRAM mux stay in the top module.

Test Plan:
- Write addr0 mask=11 data=0x0123..AB, then read addr0 -> resp_data=written value exactly 2 cycles after the read grant.
- Write addr1 mask=01 data=0xFFFF..FF over prior 0 -> next read addr1 returns lower 48 bits all-ones, upper 48 bits 0.
- wr_valid and rd_valid held high every cycle with resp_ready=1 -> grants alternate W,R,W,R starting with W after reset; no starvation.
- resp_ready=0 with 4 reads offered -> exactly 2 accepted, then rd_ready=0. Release resp_ready -> both responses delivered in order, then reads resume.
- Read granted, then reset_n=0 the next cycle -> resp_valid=0 after reset, FIFO empty, no stale response appears.
- Write and read to the same address offered in the same cycle with prio=READ -> read returns the old data, and a subsequent read returns the new data.
